// File: rtl/mdu_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// master: issuing pipeline stage; slave: the MDU itself.
interface mdu_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport master (
        output flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, busy
    );

    modport slave (
        input  flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, busy
    );
endinterface

// File: rtl/mdu_iterative.sv
// Multi-cycle RV32M/RV64M multiply/divide unit.
// Multiply: radix-2 shift-add over XLEN iterations plus one sign-fix cycle.
// Divide: restoring division over XLEN iterations plus one sign-fix cycle.
// Divide-by-zero and signed overflow bypass iteration (latency 1).
// Optional: define MDU_FAST_MUL_EN to replace the iterative multiply with a
// single registered multiplier (latency 1); divide path is unchanged.
module mdu_iterative #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic  clk,
    input  logic  rst,
    mdu_if.slave  bus
);
    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           st;
    logic [2:0]       op_q;
    logic [TAG_W-1:0] tag_q;
    logic [XLEN-1:0]  acc_hi;    // product high half / partial remainder
    logic [XLEN-1:0]  acc_lo;    // multiplier -> product low half / dividend -> quotient
    logic [XLEN-1:0]  b_q;       // |b|
    logic [CNT_W-1:0] cnt;
    logic             neg_q;     // product or quotient must be negated
    logic             neg_r;     // remainder must be negated
    logic             special_q; // precomputed divide corner result sits in acc_lo

    // operand signedness by funct3: MULH, MULHSU, DIV, REM treat a as signed;
    // only MULH, DIV, REM treat b as signed
    logic a_is_s, b_is_s, sgn_a, sgn_b;
    assign a_is_s = (bus.in_op == 3'd1) || (bus.in_op == 3'd2) ||
                    (bus.in_op == 3'd4) || (bus.in_op == 3'd6);
    assign b_is_s = (bus.in_op == 3'd1) || (bus.in_op == 3'd4) || (bus.in_op == 3'd6);
    assign sgn_a  = a_is_s & bus.in_a[XLEN-1];
    assign sgn_b  = b_is_s & bus.in_b[XLEN-1];

    logic [XLEN-1:0] a_mag, b_mag;
    assign a_mag = sgn_a ? -bus.in_a : bus.in_a;
    assign b_mag = sgn_b ? -bus.in_b : bus.in_b;

    // divide corner cases resolved at accept time
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;
    assign div_zero    = bus.in_op[2] && (bus.in_b == '0);
    assign div_ovf     = bus.in_op[2] && !bus.in_op[0] &&
                         (bus.in_a == SMIN) && (bus.in_b == '1);
    assign special     = div_zero || div_ovf;
    assign special_res = div_zero ? (bus.in_op[1] ? bus.in_a : '1)
                                  : (bus.in_op[1] ? '0 : bus.in_a);

    // one restoring-division step: shift in next dividend bit, trial subtract
    logic [XLEN:0] div_sh;
    logic          div_ok;
    assign div_sh = {acc_hi, acc_lo[XLEN-1]};
    assign div_ok = div_sh >= {1'b0, b_q};

    // final product: iterative accumulator or single multiplier
    logic [2*XLEN-1:0] mul_prod, mul_sgn;
`ifdef MDU_FAST_MUL_EN
    assign mul_prod = {{XLEN{1'b0}}, acc_lo} * {{XLEN{1'b0}}, b_q};
`else
    logic [XLEN:0] mul_sum;
    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_q} : '0);
    assign mul_prod = {acc_hi, acc_lo};
`endif
    assign mul_sgn = neg_q ? -mul_prod : mul_prod;

    logic [XLEN-1:0] mul_res, div_res;
    assign mul_res = (op_q == 3'd0) ? mul_sgn[XLEN-1:0] : mul_sgn[2*XLEN-1:XLEN];
    assign div_res = op_q[1] ? (neg_r ? -acc_hi : acc_hi)
                             : (neg_q ? -acc_lo : acc_lo);

    // control FSM and datapath; all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st             <= IDLE;
            op_q           <= '0;
            tag_q          <= '0;
            acc_hi         <= '0;
            acc_lo         <= '0;
            b_q            <= '0;
            cnt            <= '0;
            neg_q          <= 1'b0;
            neg_r          <= 1'b0;
            special_q      <= 1'b0;
            bus.in_ready   <= 1'b1;
            bus.out_valid  <= 1'b0;
            bus.out_result <= '0;
            bus.out_tag    <= '0;
            bus.busy       <= 1'b0;
        end else if (bus.flush && st != IDLE) begin
            st            <= IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.busy      <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (bus.in_valid && !bus.flush) begin
                        op_q         <= bus.in_op;
                        tag_q        <= bus.in_tag;
                        acc_hi       <= '0;
                        acc_lo       <= special ? special_res : a_mag;
                        b_q          <= b_mag;
                        cnt          <= '0;
                        neg_q        <= sgn_a ^ sgn_b;
                        neg_r        <= sgn_a;
                        special_q    <= special;
                        st           <= bus.in_op[2] ? DIV : MUL;
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                    end
                end
                MUL: begin
`ifdef MDU_FAST_MUL_EN
                    bus.out_result <= mul_res;
                    bus.out_tag    <= tag_q;
                    bus.out_valid  <= 1'b1;
                    st             <= DONE;
`else
                    if (cnt == CNT_W'(XLEN)) begin
                        bus.out_result <= mul_res;
                        bus.out_tag    <= tag_q;
                        bus.out_valid  <= 1'b1;
                        st             <= DONE;
                    end else begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[XLEN-1:1]};
                        cnt              <= cnt + CNT_W'(1);
                    end
`endif
                end
                DIV: begin
                    if (special_q) begin
                        bus.out_result <= acc_lo;
                        bus.out_tag    <= tag_q;
                        bus.out_valid  <= 1'b1;
                        st             <= DONE;
                    end else if (cnt == CNT_W'(XLEN)) begin
                        bus.out_result <= div_res;
                        bus.out_tag    <= tag_q;
                        bus.out_valid  <= 1'b1;
                        st             <= DONE;
                    end else begin
                        acc_hi <= div_ok ? XLEN'(div_sh - {1'b0, b_q}) : XLEN'(div_sh);
                        acc_lo <= {acc_lo[XLEN-2:0], div_ok};
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        st            <= IDLE;
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        bus.busy      <= 1'b0;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative (XLEN=32): directed corner cases,
// backpressure, flush, async reset, then randomized ops against a
// plain-arithmetic reference model.
module tb_mdu_iterative;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mdu_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus();

    mdu_iterative #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    // reference result from RISC-V M-extension semantics
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin q = sa * sb; p = q; return p[63:32]; end
            3'd2: begin q = sa * longint'({32'b0, b}); p = q; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                q = sa / sb; p = q; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                q = sa % sb; p = q; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
        if (!op[2]) return MUL_LAT;
        return XLEN + 1;
    endfunction

    // compare process: tracks the one outstanding op and checks outputs each cycle
    logic              pend = 1'b0, seen = 1'b0, late = 1'b0;
    int                since = 0, exp_lat = 0;
    logic [31:0]       exp_res = '0;
    logic [TAG_W-1:0]  exp_tag = '0;

    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend) since++;
            if (bus.out_valid) begin
                vectors++;
                if (!pend) begin
                    miscompares++;
                    $display("FAIL spurious_valid: out_valid=1 result=%h with nothing outstanding", bus.out_result);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        if (since != exp_lat + 1) begin
                            miscompares++;
                            $display("FAIL latency: got %0d cycles, want %0d", since - 1, exp_lat);
                        end
                    end
                    if (bus.out_result !== exp_res || bus.out_tag !== exp_tag ||
                        bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
                        miscompares++;
                        $display("FAIL result: got res=%h tag=%0d in_ready=%b busy=%b, want res=%h tag=%0d in_ready=0 busy=1",
                                 bus.out_result, bus.out_tag, bus.in_ready, bus.busy, exp_res, exp_tag);
                    end
                end
                if (bus.out_ready || bus.flush) pend = 1'b0;
            end else if (pend && seen) begin
                vectors++;
                miscompares++;
                $display("FAIL valid_dropped: out_valid fell without handshake, want 1");
                pend = 1'b0;
            end else if (pend && !late && since > exp_lat + 1) begin
                vectors++;
                miscompares++;
                late = 1'b1;
                $display("FAIL late: out_valid still 0 after %0d cycles, want %0d", since - 1, exp_lat);
            end
            if (bus.flush) pend = 1'b0;
            if (bus.in_valid && bus.in_ready && !bus.flush) begin
                pend    = 1'b1;
                seen    = 1'b0;
                late    = 1'b0;
                since   = 0;
                exp_res = ref_res(bus.in_op, bus.in_a, bus.in_b);
                exp_tag = bus.in_tag;
                exp_lat = ref_lat(bus.in_op, bus.in_a, bus.in_b);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // all driver tasks start and end at posedge+1
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
        int n = 0;
        while (!bus.in_ready && n < 200) begin @(posedge clk); #1; n++; end
        check("in_ready_wait", {31'b0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_op    = 3'($urandom);
        bus.in_a     = $urandom;
        bus.in_b     = $urandom;
        bus.in_tag   = TAG_W'($urandom);
    endtask

    task automatic retire(input int hold);
        int n = 0;
        while (!bus.out_valid && n < 100) begin @(posedge clk); #1; n++; end
        if (!bus.out_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL out_valid_timeout: out_valid=0 after %0d cycles, want 1", n);
            return;
        end
        repeat (hold) begin @(posedge clk); #1; end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("retire_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("retire_out_valid", {31'b0, bus.out_valid}, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return $urandom_range(0, 255);
            default: return $urandom;
        endcase
    endfunction

    logic [2:0]  d_op  [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] d_a   [12] = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd7,
                               32'd100, 32'd100, 32'h1234, 32'h1234, 32'h80000000, 32'h80000000};
    logic [31:0] d_b   [12] = '{32'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE,
                               32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] d_exp [12] = '{32'h14, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h1,
                               32'd14, 32'd2, 32'hFFFFFFFF, 32'h1234, 32'h80000000, 32'h0};

    initial begin
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0;
        bus.in_b = '0; bus.in_tag = '0; bus.out_ready = 1'b0;

        // reset state
        #12;
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_out_result", bus.out_result, 32'h0);
        check("rst_out_tag", 32'(bus.out_tag), 32'h0);
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;

        // pin the model, then run the same vectors through the DUT
        check("model_lat_mul", ref_lat(3'd0, 32'd5, 32'd4), MUL_LAT);
        check("model_lat_div0", ref_lat(3'd4, 32'h1234, 32'd0), 32'd1);
        check("model_lat_div", ref_lat(3'd5, 32'd100, 32'd7), 32'd33);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("model_vec%0d", i), ref_res(d_op[i], d_a[i], d_b[i]), d_exp[i]);
            send(d_op[i], d_a[i], d_b[i], TAG_W'(i + 1));
            retire(0);
        end

        // backpressure: hold out_ready low 10 cycles in DONE
        send(3'd5, 32'd1000, 32'd3, 5'd17);
        retire(10);

        // flush in IDLE suppresses acceptance
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_op = 3'd0;
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        check("idle_flush_busy", {31'b0, bus.busy}, 32'd0);
        check("idle_flush_in_ready", {31'b0, bus.in_ready}, 32'd1);

        // flush at iteration 10 of a DIV, then a fresh MUL
        send(3'd4, 32'd1000, 32'd7, 5'd3);
        repeat (10) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_busy", {31'b0, bus.busy}, 32'd0);
        check("flush_in_ready", {31'b0, bus.in_ready}, 32'd1);
        repeat (40) begin @(posedge clk); #1; end
        send(3'd0, 32'd3, 32'd3, 5'd9);
        retire(0);

        // async reset mid-MUL
        send(3'd0, 32'd5, 32'd4, 5'd11);
        repeat (5) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        check("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("midrst_busy", {31'b0, bus.busy}, 32'd0);
        check("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("midrst_out_result", bus.out_result, 32'h0);
        @(posedge clk); #1; rst = 1'b0;
        repeat (40) begin @(posedge clk); #1; end
        send(3'd0, 32'd5, 32'd4, 5'd12);
        retire(0);

        // randomized ops with random backpressure and occasional flush
        for (int i = 0; i < 150; i++) begin
            send(3'($urandom_range(0, 7)), pick(), pick(), TAG_W'($urandom));
            if ($urandom_range(0, 15) == 0) begin
                repeat ($urandom_range(0, 40)) begin @(posedge clk); #1; end
                bus.flush = 1'b1;
                @(posedge clk); #1;
                bus.flush = 1'b0;
            end else begin
                retire($urandom_range(0, 3));
            end
        end

        repeat (3) begin @(posedge clk); #1; end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
